memory_stage: RTL

- Fills the MEM stage slot between the EX/MEM barrier and MEM_WB_Barrier.
- Performs loads and stores against an external data memory through a req/ready handshake.
- Aligns and extends load data, stalls the pipeline while an access is outstanding, and drives the MEM_WB_Barrier inputs (memMemoryData, memExecutionData, memShouldUseMemoryData, memIsRegisterWrite).

---
 rtl/mem_pkg.sv | 27 ++
 rtl/load_store_align.sv | 68 ++++++
 rtl/memory_stage.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mem_pkg
// Brief   : Shared constants and FSM state type for the MEM pipeline stage.
// Revision: 1.0 - initial release
// ============================================================================
package mem_pkg;

  localparam logic [2:0] c_F3_LB  = 3'b000;
  localparam logic [2:0] c_F3_LH  = 3'b001;
  localparam logic [2:0] c_F3_LW  = 3'b010;
  localparam logic [2:0] c_F3_LBU = 3'b100;
  localparam logic [2:0] c_F3_LHU = 3'b101;
  localparam logic [2:0] c_F3_SB  = 3'b000;
  localparam logic [2:0] c_F3_SH  = 3'b001;
  localparam logic [2:0] c_F3_SW  = 3'b010;

  localparam int c_BE_WIDTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } mem_state_e;

endpackage
`default_nettype wire

// File: rtl/load_store_align.sv
`default_nettype none
// ============================================================================
// Module  : load_store_align
// Brief   : Byte-lane enables, store replication, alignment check, load extension.
// Revision: 1.0 - initial release
// ============================================================================
module load_store_align
  import mem_pkg::*;
(
  input  logic [1:0]            addr_lo_i,
  input  logic [2:0]            funct3_i,
  input  logic                  is_write_i,
  input  logic [31:0]           store_data_i,
  input  logic [31:0]           rdata_i,
  output logic [c_BE_WIDTH-1:0] byte_en_o,
  output logic [31:0]           wdata_o,
  output logic                  misaligned_o,
  output logic [31:0]           load_data_o
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // funct3[1:0] gives the access size: 00 byte, 01 half, anything else a word
  always_comb begin
    misaligned_o = ((funct3_i[1:0] == 2'b01) && addr_lo_i[0]) ||
                   (funct3_i[1] && (addr_lo_i != 2'b00));

    byte_en_o = 4'b1111;
    wdata_o   = store_data_i;
    if (is_write_i) begin
      case (funct3_i[1:0])
        2'b00: begin
          byte_en_o = 4'b0001 << addr_lo_i;
          wdata_o   = {4{store_data_i[7:0]}};
        end
        2'b01: begin
          byte_en_o = 4'b0011 << addr_lo_i;
          wdata_o   = {2{store_data_i[15:0]}};
        end
        default: begin
          byte_en_o = 4'b1111;
          wdata_o   = store_data_i;
        end
      endcase
    end
  end

  always_comb begin
    case (addr_lo_i)
      2'd0:    w_byte = rdata_i[7:0];
      2'd1:    w_byte = rdata_i[15:8];
      2'd2:    w_byte = rdata_i[23:16];
      default: w_byte = rdata_i[31:24];
    endcase
    w_half = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    case (funct3_i)
      c_F3_LB:  load_data_o = {{24{w_byte[7]}}, w_byte};
      c_F3_LH:  load_data_o = {{16{w_half[15]}}, w_half};
      c_F3_LBU: load_data_o = {24'd0, w_byte};
      c_F3_LHU: load_data_o = {16'd0, w_half};
      default:  load_data_o = rdata_i;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/memory_stage.sv
`default_nettype none
// ============================================================================
// Module  : memory_stage
// Brief   : MEM pipeline stage: data-memory handshake, stall and MEM/WB drive.
// Revision: 1.0 - initial release
// ============================================================================
module memory_stage
  import mem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int ADDR_WIDTH     = 32
) (
  input  logic                  clk,
  input  logic                  nReset,
  input  logic                  exValid,
  input  logic [31:0]           exExecutionData,
  input  logic [31:0]           exStoreData,
  input  logic [2:0]            exFunct3,
  input  logic                  exMemRead,
  input  logic                  exMemWrite,
  input  logic                  exIsRegisterWrite,
  output logic                  dmemReq,
  output logic                  dmemWe,
  output logic [ADDR_WIDTH-1:0] dmemAddr,
  output logic [3:0]            dmemByteEnable,
  output logic [31:0]           dmemWData,
  input  logic [31:0]           dmemRData,
  input  logic                  dmemReady,
  output logic                  memStall,
  output logic [31:0]           memMemoryData,
  output logic [31:0]           memExecutionData,
  output logic                  memShouldUseMemoryData,
  output logic                  memIsRegisterWrite,
  output logic                  misaligned,
  output logic                  busError
);

  localparam int              c_CW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_CW-1:0] c_CNT_LAST = c_CW'(TIMEOUT_CYCLES - 1);

  mem_state_e        state_q;
  logic [c_CW-1:0]   cnt_q;
  logic [31:0]       data_q;
  logic              timeout_q;

  logic              w_memop;
  logic              w_is_write;
  logic              w_misal;
  logic [3:0]        w_be;
  logic [31:0]       w_wdata;
  logic [31:0]       w_load;

  assign w_memop    = exValid & (exMemRead | exMemWrite);
  assign w_is_write = exValid & exMemWrite;

  load_store_align u_align (
    .addr_lo_i    (exExecutionData[1:0]),
    .funct3_i     (exFunct3),
    .is_write_i   (w_is_write),
    .store_data_i (exStoreData),
    .rdata_i      (dmemRData),
    .byte_en_o    (w_be),
    .wdata_o      (w_wdata),
    .misaligned_o (w_misal),
    .load_data_o  (w_load)
  );

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      data_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (w_memop && !w_misal) begin
            state_q   <= ST_WAIT;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (dmemReady) begin
            data_q  <= w_load;
            state_q <= ST_RESP;
          end else if (cnt_q == c_CNT_LAST) begin
            data_q    <= '0;
            timeout_q <= 1'b1;
            state_q   <= ST_RESP;
          end else begin
            cnt_q <= cnt_q + c_CW'(1);
          end
        end
        ST_RESP: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Outputs are forced to their reset values while nReset is low, even though
  // most of them are combinational functions of the EX/MEM inputs.
  always_comb begin
    dmemReq                = 1'b0;
    dmemWe                 = 1'b0;
    dmemAddr               = '0;
    dmemByteEnable         = 4'b1111;
    dmemWData              = '0;
    memStall               = 1'b0;
    memMemoryData          = '0;
    memExecutionData       = '0;
    memShouldUseMemoryData = 1'b0;
    memIsRegisterWrite     = 1'b0;
    misaligned             = 1'b0;
    busError               = 1'b0;
    if (nReset) begin
      memExecutionData = exExecutionData;
      dmemWe           = w_is_write;
      dmemAddr         = {exExecutionData[ADDR_WIDTH-1:2], 2'b00};
      dmemByteEnable   = w_be;
      dmemWData        = w_wdata;
      case (state_q)
        ST_IDLE: begin
          if (w_memop) begin
            if (w_misal) begin
              misaligned = 1'b1;
            end else begin
              dmemReq  = 1'b1;
              memStall = 1'b1;
            end
          end else begin
            memIsRegisterWrite = exValid & exIsRegisterWrite;
          end
        end
        ST_WAIT: begin
          dmemReq  = 1'b1;
          memStall = 1'b1;
        end
        ST_RESP: begin
          memMemoryData          = data_q;
          memShouldUseMemoryData = exMemRead;
          memIsRegisterWrite     = exIsRegisterWrite & exMemRead & ~timeout_q;
          busError               = timeout_q;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire
